// File: rtl/uart_baudgen_frac.sv
// Fractional UART baud generator.
// Produces an oversample tick (os_tick) whose period alternates between
// floor and ceil of a fixed-point divider so that the average period is
// exactly A_INT + A_FRAC/2^FRAC_W cycles. A sub-counter over the
// oversample ratio derives a bit-midpoint tick and an end-of-bit tick.
// New configurations are staged in a shadow copy and only become active
// at a bit boundary, on a phase resync, or while disabled, so a running
// bit is never shortened or split.
//
// Handshake/timing contract: all inputs are sampled on the rising edge of
// clk; cfg_load and sync are single-cycle pulses acted on in the cycle they
// are seen. All outputs are registered, so a terminal count sampled at edge
// k shows up on os_tick/mid_tick/bit_tick during the cycle after edge k.
module uart_baudgen_frac #(
  parameter int INT_W            = 16,
  parameter int FRAC_W           = 4,
  parameter int CLK_HZ           = 50_000_000,
  parameter int DEFAULT_BAUDRATE = 9_600
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_load,
  input  logic [INT_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  input  logic [1:0]        cfg_osr,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              cfg_pending
);

  // Default divider in FRAC_W fixed point, rounded to nearest:
  // D = round(CLK_HZ * 2^FRAC_W / (DEFAULT_BAUDRATE * 16)).
  localparam logic [63:0] DEF_NUM  = 64'(CLK_HZ) << FRAC_W;
  localparam logic [63:0] DEF_DEN  = 64'(DEFAULT_BAUDRATE) * 64'd16;
  localparam logic [63:0] DEF_D    = (DEF_NUM + (DEF_DEN >> 1)) / DEF_DEN;
  localparam logic [63:0] FRAC_MOD = 64'd1 << FRAC_W;

  localparam logic [INT_W-1:0]  DEF_INT  = INT_W'(DEF_D >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_D % FRAC_MOD);
  // Oversample ratio is held as its last sub index (OSR-1): 15, 7 or 3.
  localparam logic [3:0]        DEF_LAST = 4'd15;
  localparam logic [INT_W:0]    ONE      = {{INT_W{1'b0}}, 1'b1};

  // Map the 2-bit ratio code to the last sub-counter index.
  function automatic logic [3:0] osr_last(input logic [1:0] code);
    logic [3:0] last;
    case (code)
      2'd1:    last = 4'd7;   // 8x
      2'd2:    last = 4'd3;   // 4x
      default: last = 4'd15;  // 16x for codes 0 and 3
    endcase
    return last;
  endfunction

  // Active configuration (drives the counters) and its shadow.
  logic [INT_W-1:0]  a_int,  s_int;
  logic [FRAC_W-1:0] a_frac, s_frac;
  logic [3:0]        a_last, s_last;

  // Timing state.
  logic [INT_W:0]    cnt;
  logic [FRAC_W-1:0] acc;
  logic [3:0]        sub;

  // Combinational decode of the current period and events.
  logic [INT_W:0]    int_eff;
  logic [FRAC_W:0]   frac_sum;
  logic              carry;
  logic [INT_W:0]    period;
  logic [INT_W:0]    cnt_last;
  logic [3:0]        mid_idx;
  logic              term;
  logic              at_bit;
  logic              at_mid;
  logic              apply_evt;
  logic              apply;

  // Period of the current oversample tick and the events derived from it.
  always_comb begin
    int_eff   = (a_int == '0) ? ONE : {1'b0, a_int};
    frac_sum  = {1'b0, acc} + {1'b0, a_frac};
    carry     = frac_sum[FRAC_W];
    period    = int_eff + {{INT_W{1'b0}}, carry};
    cnt_last  = period - ONE;
    mid_idx   = {1'b0, a_last[3:1]};
    // sync wins over a terminal count in the same cycle.
    term      = en && !sync && (cnt == cnt_last);
    at_bit    = term && (sub == a_last);
    at_mid    = term && (sub == mid_idx);
    // Safe points to switch configuration: disabled, resync, or bit end.
    apply_evt = !en || sync || at_bit;
    // A load coinciding with a safe point defers the switch to the next one.
    apply     = apply_evt && cfg_pending && !cfg_load;
  end

  // Cycle counter, fraction accumulator and oversample sub-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      sub <= '0;
    end else if (!en || sync) begin
      cnt <= '0;
      acc <= '0;
      sub <= '0;
    end else if (term) begin
      cnt <= '0;
      acc <= frac_sum[FRAC_W-1:0];
      sub <= (sub == a_last) ? 4'd0 : sub + 4'd1;
    end else begin
      cnt <= cnt + ONE;
    end
  end

  // Registered tick outputs, one cycle after the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      os_tick  <= term;
      mid_tick <= at_mid;
      bit_tick <= at_bit;
    end
  end

  // Shadow capture; cfg_div_int of zero selects the default divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_int  <= DEF_INT;
      s_frac <= DEF_FRAC;
      s_last <= DEF_LAST;
    end else if (cfg_load) begin
      if (cfg_div_int == '0) begin
        s_int  <= DEF_INT;
        s_frac <= DEF_FRAC;
      end else begin
        s_int  <= cfg_div_int;
        s_frac <= cfg_div_frac;
      end
      s_last <= osr_last(cfg_osr);
    end
  end

  // Active configuration update at a safe point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_int  <= DEF_INT;
      a_frac <= DEF_FRAC;
      a_last <= DEF_LAST;
    end else if (apply) begin
      a_int  <= s_int;
      a_frac <= s_frac;
      a_last <= s_last;
    end
  end

  // Pending flag: set by a load, cleared when the shadow is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_pending <= 1'b0;
    end else if (cfg_load) begin
      cfg_pending <= 1'b1;
    end else if (apply) begin
      cfg_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_baudgen_frac.sv
// Directed bench for uart_baudgen_frac with default parameters
// (50 MHz clock, 9600 baud default => divider 325 + 8/16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_baudgen_frac;

  localparam int INT_W      = 16;
  localparam int FRAC_W     = 4;
  localparam int WAIT_LIMIT = 20000;
  localparam int SEL_OS     = 0;
  localparam int SEL_MID    = 1;
  localparam int SEL_BIT    = 2;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              sync;
  logic              cfg_load;
  logic [INT_W-1:0]  cfg_div_int;
  logic [FRAC_W-1:0] cfg_div_frac;
  logic [1:0]        cfg_osr;
  logic              os_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic              cfg_pending;

  int total;
  int bad;

  uart_baudgen_frac #(
    .INT_W(INT_W),
    .FRAC_W(FRAC_W),
    .CLK_HZ(50_000_000),
    .DEFAULT_BAUDRATE(9_600)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .sync(sync),
    .cfg_load(cfg_load),
    .cfg_div_int(cfg_div_int),
    .cfg_div_frac(cfg_div_frac),
    .cfg_osr(cfg_osr),
    .os_tick(os_tick),
    .mid_tick(mid_tick),
    .bit_tick(bit_tick),
    .cfg_pending(cfg_pending)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Count falling edges until the selected tick is seen; -1 on timeout.
  task automatic wait_tick(input int which, output int n);
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
      case (which)
        SEL_OS:  hit = (os_tick === 1'b1);
        SEL_MID: hit = (mid_tick === 1'b1);
        default: hit = (bit_tick === 1'b1);
      endcase
    end
    if (!hit) n = -1;
  endtask

  task automatic load_cfg(input int di, input int df, input int osr);
    cfg_div_int  = INT_W'(di);
    cfg_div_frac = FRAC_W'(df);
    cfg_osr      = 2'(osr);
    cfg_load     = 1'b1;
    step();
    cfg_load     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; cfg_load = 1'b0;
    cfg_div_int = '0; cfg_div_frac = '0; cfg_osr = '0;
    step(); step();
    total++; if (os_tick !== 1'b0) begin bad++; $display("FAIL reset_os: got %b want 0", os_tick); end
    total++; if (mid_tick !== 1'b0) begin bad++; $display("FAIL reset_mid: got %b want 0", mid_tick); end
    total++; if (bit_tick !== 1'b0) begin bad++; $display("FAIL reset_bit: got %b want 0", bit_tick); end
    total++; if (cfg_pending !== 1'b0) begin bad++; $display("FAIL reset_pending: got %b want 0", cfg_pending); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    total++; if (os_tick !== 1'b0) begin bad++; $display("FAIL disabled_quiet: got %b want 0", os_tick); end
  endtask

  task automatic test_default();
    int n;
    int exp_os[4] = '{325, 326, 325, 326};
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tick(SEL_OS, n);
      total++; if (n !== exp_os[i]) begin bad++; $display("FAIL default_os_%0d: got %0d want %0d", i, n, exp_os[i]); end
    end
    wait_tick(SEL_BIT, n);
    wait_tick(SEL_BIT, n);
    total++; if (n !== 5208) begin bad++; $display("FAIL default_bit_period: got %0d want 5208", n); end
  endtask

  task automatic test_cfg_idle();
    int n;
    int exp_os[4] = '{2, 3, 2, 3};
    en = 1'b0;
    step();
    load_cfg(2, 8, 1);
    total++; if (cfg_pending !== 1'b1) begin bad++; $display("FAIL idle_pending_set: got %b want 1", cfg_pending); end
    step();
    total++; if (cfg_pending !== 1'b0) begin bad++; $display("FAIL idle_pending_clr: got %b want 0", cfg_pending); end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tick(SEL_OS, n);
      total++; if (n !== exp_os[i]) begin bad++; $display("FAIL idle_os_%0d: got %0d want %0d", i, n, exp_os[i]); end
    end
    wait_tick(SEL_BIT, n);
    total++; if (n !== 10) begin bad++; $display("FAIL idle_first_bit: got %0d want 10", n); end
    wait_tick(SEL_MID, n);
    total++; if (n !== 10) begin bad++; $display("FAIL idle_bit_to_mid: got %0d want 10", n); end
    wait_tick(SEL_BIT, n);
    total++; if (n !== 10) begin bad++; $display("FAIL idle_mid_to_bit: got %0d want 10", n); end
    wait_tick(SEL_BIT, n);
    total++; if (n !== 20) begin bad++; $display("FAIL idle_bit_period: got %0d want 20", n); end
  endtask

  task automatic test_cfg_midbit();
    int n;
    for (int i = 0; i < 6; i++) step();
    load_cfg(3, 0, 0);
    total++; if (cfg_pending !== 1'b1) begin bad++; $display("FAIL midbit_pending_set: got %b want 1", cfg_pending); end
    wait_tick(SEL_BIT, n);
    total++; if (n !== 13) begin bad++; $display("FAIL midbit_old_bit_end: got %0d want 13", n); end
    total++; if (cfg_pending !== 1'b0) begin bad++; $display("FAIL midbit_pending_clr: got %b want 0", cfg_pending); end
    for (int i = 0; i < 2; i++) begin
      wait_tick(SEL_OS, n);
      total++; if (n !== 3) begin bad++; $display("FAIL midbit_new_os_%0d: got %0d want 3", i, n); end
    end
  endtask

  task automatic test_sync();
    int n;
    wait_tick(SEL_OS, n);
    for (int i = 0; i < 4; i++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    total++; if (os_tick !== 1'b0) begin bad++; $display("FAIL sync_no_tick: got %b want 0", os_tick); end
    wait_tick(SEL_OS, n);
    total++; if (n !== 3) begin bad++; $display("FAIL sync_first_os: got %0d want 3", n); end
    wait_tick(SEL_MID, n);
    total++; if (n !== 21) begin bad++; $display("FAIL sync_mid: got %0d want 21", n); end
    // Sync landing on a terminal-count cycle must suppress that tick.
    step(); step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    total++; if (os_tick !== 1'b0) begin bad++; $display("FAIL sync_priority: got %b want 0", os_tick); end
    wait_tick(SEL_OS, n);
    total++; if (n !== 3) begin bad++; $display("FAIL sync_priority_next: got %0d want 3", n); end
  endtask

  task automatic test_load_on_apply();
    int n;
    load_cfg(3, 0, 2);
    wait_tick(SEL_BIT, n);
    total++; if (cfg_pending !== 1'b0) begin bad++; $display("FAIL loadapply_setup_clr: got %b want 0", cfg_pending); end
    wait_tick(SEL_BIT, n);
    total++; if (n !== 12) begin bad++; $display("FAIL loadapply_4x_period: got %0d want 12", n); end
    for (int i = 0; i < 11; i++) step();
    load_cfg(2, 0, 2);
    total++; if (bit_tick !== 1'b1) begin bad++; $display("FAIL loadapply_coincide_bit: got %b want 1", bit_tick); end
    total++; if (cfg_pending !== 1'b1) begin bad++; $display("FAIL loadapply_still_pending: got %b want 1", cfg_pending); end
    wait_tick(SEL_BIT, n);
    total++; if (n !== 12) begin bad++; $display("FAIL loadapply_old_kept: got %0d want 12", n); end
    total++; if (cfg_pending !== 1'b0) begin bad++; $display("FAIL loadapply_applied: got %b want 0", cfg_pending); end
    wait_tick(SEL_BIT, n);
    total++; if (n !== 8) begin bad++; $display("FAIL loadapply_new_period: got %0d want 8", n); end
  endtask

  task automatic test_reset_midbit();
    int n;
    step();
    load_cfg(5, 0, 0);
    wait_tick(SEL_OS, n);
    total++; if (cfg_pending !== 1'b1) begin bad++; $display("FAIL rstmid_pre_pending: got %b want 1", cfg_pending); end
    #1;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    total++; if (os_tick !== 1'b0) begin bad++; $display("FAIL rstmid_os: got %b want 0", os_tick); end
    total++; if (cfg_pending !== 1'b0) begin bad++; $display("FAIL rstmid_pending: got %b want 0", cfg_pending); end
    total++; if ((mid_tick | bit_tick) !== 1'b0) begin bad++; $display("FAIL rstmid_mid_bit: got %b want 0", mid_tick | bit_tick); end
    step(); step();
    rst_n = 1'b1;
    en    = 1'b1;
    step();
    en    = 1'b0;
    step();
    en    = 1'b1;
    wait_tick(SEL_OS, n);
    total++; if (n !== 325) begin bad++; $display("FAIL rstmid_first_os: got %0d want 325", n); end
    wait_tick(SEL_OS, n);
    total++; if (n !== 326) begin bad++; $display("FAIL rstmid_second_os: got %0d want 326", n); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_default();
    test_cfg_idle();
    test_cfg_midbit();
    test_sync();
    test_load_on_apply();
    test_reset_midbit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
